// File: rtl/demosaic_pkg.sv
// Shared Bayer definitions for the mosaic encoder and the demosaic interpolators.
package demosaic_pkg;

   localparam int unsigned PIX_W_DEF = 10;

   // Phase of the 2x2 tile, named by its top-left and top-right / bottom rows
   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_pattern_t;

   // Colour at each site index of an RGGB-referenced tile
   localparam logic [1:0] SITE_R  = 2'd0;
   localparam logic [1:0] SITE_GR = 2'd1;
   localparam logic [1:0] SITE_GB = 2'd2;
   localparam logic [1:0] SITE_B  = 2'd3;

   // XOR-ing the parity pair with the phase maps any pattern onto the RGGB site table
   function automatic logic [1:0] site_idx(input logic row_par, input logic col_par,
                                           input bayer_pattern_t pat);
      return {row_par, col_par} ^ 2'(pat);
   endfunction

endpackage

// File: rtl/bayer_mosaic_encoder_if.sv
// Pixel stream bundle: RGB input side (s_*) and raw mosaic output side (m_*).
interface bayer_mosaic_encoder_if
   import demosaic_pkg::*;
#(
   parameter int unsigned PIX_W = PIX_W_DEF
);
   logic [PIX_W-1:0] s_r;
   logic [PIX_W-1:0] s_g;
   logic [PIX_W-1:0] s_b;
   logic             s_valid;
   logic             s_sof;
   logic             s_eol;
   logic             s_ready;
   logic [PIX_W-1:0] m_data;
   logic             m_valid;
   logic             m_sof;
   logic             m_eol;
   logic             m_ready;

   // Encoder view
   modport slave (
      input  s_r, s_g, s_b, s_valid, s_sof, s_eol, m_ready,
      output s_ready, m_data, m_valid, m_sof, m_eol
   );

   // Source/sink view
   modport master (
      output s_r, s_g, s_b, s_valid, s_sof, s_eol, m_ready,
      input  s_ready, m_data, m_valid, m_sof, m_eol
   );
endinterface

// File: rtl/mosaic_skid_buf.sv
// Two-entry output buffer; o_ready is registered so i_ready never reaches it combinationally.
module mosaic_skid_buf #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);
   logic [WIDTH-1:0] r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_cnt;
   logic             r_ready;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_cnt_nxt;

   // Occupancy bookkeeping
   always_comb begin
      w_push    = i_valid && r_ready;
      w_pop     = (r_cnt != 2'd0) && i_ready;
      w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
   end

   // Storage, pointers and the look-ahead ready flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_cnt    <= 2'd0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_cnt_nxt != 2'd2);
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_valid = (r_cnt != 2'd0);
   assign o_ready = r_ready;

endmodule

// File: rtl/bayer_mosaic_encoder.sv
// Converts an RGB pixel stream into a Bayer raw mosaic with line/frame sanity checks.
module bayer_mosaic_encoder
   import demosaic_pkg::*;
#(
   parameter int unsigned PIX_W     = PIX_W_DEF,
   parameter int unsigned IMG_WIDTH = 1920
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           cfg_pattern,
   bayer_mosaic_encoder_if.slave bus,
   input  logic                 err_clr,
   output logic                 err_width,
   output logic                 err_sof,
   output logic [15:0]          frame_cnt
);
   localparam int unsigned      CNT_W    = $clog2(IMG_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] r_col_cnt;
   logic             r_col_par;
   logic             r_row_par;
   bayer_pattern_t   r_pat;
   logic             r_err_width;
   logic             r_err_sof;
   logic [15:0]      r_frame_cnt;

   logic             w_s_ready;
   logic             w_in_fire;
   bayer_pattern_t   w_pat;
   logic [CNT_W-1:0] w_cur_cnt;
   logic             w_cur_col;
   logic             w_cur_row;
   logic             w_last;
   logic             w_line_end;
   logic [1:0]       w_idx;
   logic [PIX_W-1:0] w_pix;
   logic             w_set_width;
   logic             w_set_sof;
   logic [PIX_W+1:0] w_out;

   // Position of the current beat: a sof beat always sits at row 0 / col 0
   always_comb begin
      w_in_fire   = bus.s_valid && w_s_ready;
      w_pat       = bus.s_sof ? bayer_pattern_t'(cfg_pattern) : r_pat;
      w_cur_cnt   = bus.s_sof ? '0 : r_col_cnt;
      w_cur_col   = bus.s_sof ? 1'b0 : r_col_par;
      w_cur_row   = bus.s_sof ? 1'b0 : r_row_par;
      w_last      = (w_cur_cnt == LAST_COL);
      // A full-length line without eol is closed as if eol had been seen
      w_line_end  = bus.s_eol || w_last;
      w_idx       = site_idx(w_cur_row, w_cur_col, w_pat);
      w_set_width = w_in_fire && (bus.s_eol != w_last);
      w_set_sof   = w_in_fire && bus.s_sof && (r_col_cnt != '0);
   end

   // Site select: pass the chosen channel through untouched
   always_comb begin
      w_pix = bus.s_g;
      case (w_idx)
         SITE_R:  w_pix = bus.s_r;
         SITE_B:  w_pix = bus.s_b;
         default: w_pix = bus.s_g;
      endcase
   end

   // Line/frame tracking and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_cnt   <= '0;
         r_col_par   <= 1'b0;
         r_row_par   <= 1'b0;
         r_pat       <= RGGB;
         r_err_width <= 1'b0;
         r_err_sof   <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         if (w_in_fire) begin
            r_pat <= w_pat;
            if (w_line_end) begin
               r_col_cnt <= '0;
               r_col_par <= 1'b0;
               r_row_par <= ~w_cur_row;
            end else begin
               r_col_cnt <= w_cur_cnt + CNT_ONE;
               r_col_par <= ~w_cur_col;
               r_row_par <= w_cur_row;
            end
            if (bus.s_sof) begin
               r_frame_cnt <= r_frame_cnt + 16'd1;
            end
         end
         // A set on the same cycle as err_clr takes priority
         if (w_set_width) begin
            r_err_width <= 1'b1;
         end else if (err_clr) begin
            r_err_width <= 1'b0;
         end
         if (w_set_sof) begin
            r_err_sof <= 1'b1;
         end else if (err_clr) begin
            r_err_sof <= 1'b0;
         end
      end
   end

   mosaic_skid_buf #(
      .WIDTH (PIX_W + 2)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  ({w_pix, bus.s_sof, bus.s_eol}),
      .i_valid (bus.s_valid),
      .o_ready (w_s_ready),
      .o_data  (w_out),
      .o_valid (bus.m_valid),
      .i_ready (bus.m_ready)
   );

   assign bus.s_ready = w_s_ready;
   assign bus.m_data  = w_out[PIX_W+1:2];
   assign bus.m_sof   = w_out[1];
   assign bus.m_eol   = w_out[0];
   assign err_width   = r_err_width;
   assign err_sof     = r_err_sof;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_bayer_mosaic_encoder.sv
// Directed bench for bayer_mosaic_encoder with a scoreboard of expected mosaic beats.
module tb_bayer_mosaic_encoder;
   import demosaic_pkg::*;

   localparam int unsigned PW = 10;
   localparam int unsigned IW = 4;
   localparam logic [PW-1:0] R = 10'h100;
   localparam logic [PW-1:0] G = 10'h200;
   localparam logic [PW-1:0] B = 10'h300;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  cfg_pattern;
   logic        err_clr;
   logic        err_width;
   logic        err_sof;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [PW+1:0] sb_q[$];

   bayer_mosaic_encoder_if #(.PIX_W(PW)) bus ();

   bayer_mosaic_encoder #(
      .PIX_W     (PW),
      .IMG_WIDTH (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_pattern (cfg_pattern),
      .bus         (bus),
      .err_clr     (err_clr),
      .err_width   (err_width),
      .err_sof     (err_sof),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Pop and compare whenever an output transfer happens this cycle
   task automatic mon();
      logic [PW+1:0] e;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_beat", {20'd0, bus.m_data, bus.m_sof, bus.m_eol}, 32'hDEAD);
         end else begin
            e = sb_q.pop_front();
            chk("out_beat", {20'd0, bus.m_data, bus.m_sof, bus.m_eol}, {20'd0, e});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mon();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [PW-1:0] exp_d, input logic sof, input logic eol);
      bit got;
      got = 1'b0;
      bus.s_r     = R;
      bus.s_g     = G;
      bus.s_b     = B;
      bus.s_sof   = sof;
      bus.s_eol   = eol;
      bus.s_valid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         mon();
         if (bus.s_ready === 1'b1) begin
            sb_q.push_back({exp_d, sof, eol});
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      bus.s_eol   = 1'b0;
      if (!got) chk("accept_timeout", {31'd0, bus.s_ready}, 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb_q.size() > 0; k++) idle(1);
      chk("drain_left", sb_q.size(), 32'd0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      bus.s_eol   = 1'b0;
      bus.s_r     = '0;
      bus.s_g     = '0;
      bus.s_b     = '0;
      bus.m_ready = 1'b1;
      cfg_pattern = 2'd0;
      err_clr     = 1'b0;
      #12;
      chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("rst_m_data", {22'd0, bus.m_data}, 32'd0);
      chk("rst_m_sof_eol", {30'd0, bus.m_sof, bus.m_eol}, 32'd0);
      chk("rst_errs", {30'd0, err_width, err_sof}, 32'd0);
      chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("s_ready_rise", {31'd0, bus.s_ready}, 32'd1);

      // RGGB, two full lines
      send(R, 1'b1, 1'b0);
      chk("latency_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("latency_data", {22'd0, bus.m_data}, {22'd0, R});
      send(G, 1'b0, 1'b0);
      send(R, 1'b0, 1'b0);
      send(G, 1'b0, 1'b1);
      send(G, 1'b0, 1'b0);
      send(B, 1'b0, 1'b0);
      send(G, 1'b0, 1'b0);
      send(B, 1'b0, 1'b1);
      drain();
      chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);
      chk("no_errs_1", {30'd0, err_width, err_sof}, 32'd0);

      // BGGR latched at sof; mid-frame switch to RGGB ignored
      cfg_pattern = 2'd3;
      send(B, 1'b1, 1'b0);
      cfg_pattern = 2'd0;
      send(G, 1'b0, 1'b0);
      send(B, 1'b0, 1'b0);
      send(G, 1'b0, 1'b1);
      send(G, 1'b0, 1'b0);
      send(R, 1'b0, 1'b0);
      send(G, 1'b0, 1'b0);
      send(R, 1'b0, 1'b1);
      drain();
      chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);

      // Back-pressure: buffer fills, s_ready drops, head stays stable
      bus.m_ready = 1'b0;
      send(R, 1'b1, 1'b0);
      send(G, 1'b0, 1'b0);
      chk("bp_s_ready_low", {31'd0, bus.s_ready}, 32'd0);
      idle(5);
      chk("bp_head_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("bp_head_data", {20'd0, bus.m_data, bus.m_sof, bus.m_eol}, {20'd0, R, 2'b10});
      bus.m_ready = 1'b1;
      send(R, 1'b0, 1'b0);
      send(G, 1'b0, 1'b1);
      drain();
      chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);

      // Short line, clear, then missing eol with wrap
      send(R, 1'b1, 1'b0);
      send(G, 1'b0, 1'b0);
      send(R, 1'b0, 1'b1);
      chk("short_line_err", {31'd0, err_width}, 32'd1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk("err_clr_width", {31'd0, err_width}, 32'd0);
      send(G, 1'b0, 1'b0);
      send(B, 1'b0, 1'b0);
      send(G, 1'b0, 1'b0);
      chk("no_err_mid_line", {31'd0, err_width}, 32'd0);
      send(B, 1'b0, 1'b0);
      chk("missing_eol_err", {31'd0, err_width}, 32'd1);
      send(R, 1'b0, 1'b0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      send(G, 1'b0, 1'b0);

      // sof at column 2
      send(R, 1'b1, 1'b0);
      chk("mid_line_sof_err", {31'd0, err_sof}, 32'd1);
      chk("frame_cnt_5", {16'd0, frame_cnt}, 32'd5);
      send(G, 1'b0, 1'b0);
      send(R, 1'b0, 1'b0);
      send(G, 1'b0, 1'b1);
      chk("sof_no_width_err", {31'd0, err_width}, 32'd0);

      // sof+eol on a 4-wide line while clearing: set wins for width, sof flag clears
      err_clr = 1'b1;
      send(R, 1'b1, 1'b1);
      err_clr = 1'b0;
      chk("clr_vs_set_width", {31'd0, err_width}, 32'd1);
      chk("clr_sof", {31'd0, err_sof}, 32'd0);
      chk("frame_cnt_6", {16'd0, frame_cnt}, 32'd6);
      drain();

      // Asynchronous reset with data in flight
      bus.m_ready = 1'b0;
      send(R, 1'b1, 1'b0);
      send(G, 1'b0, 1'b0);
      chk("pre_rst_valid", {31'd0, bus.m_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("async_s_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("async_m_data", {20'd0, bus.m_data, bus.m_sof, bus.m_eol}, 32'd0);
      chk("async_errs_cnt", {14'd0, err_width, err_sof, frame_cnt}, 32'd0);
      sb_q.delete();
      bus.m_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("s_ready_rise_2", {31'd0, bus.s_ready}, 32'd1);
      cfg_pattern = 2'd3;
      send(B, 1'b1, 1'b0);
      send(G, 1'b0, 1'b0);
      send(B, 1'b0, 1'b0);
      send(G, 1'b0, 1'b1);
      drain();
      chk("frame_cnt_after_rst", {16'd0, frame_cnt}, 32'd1);
      chk("errs_after_rst", {30'd0, err_width, err_sof}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bayer_mosaic_encoder.md
BAYER_MOSAIC_ENCODER -- requirements
Module: bayer_mosaic_encoder

Interface
REQ-001 SHALL have parameter PIX_W, default 10, per-channel and raw sample width.
REQ-002 SHALL have parameter IMG_WIDTH, default 1920, expected pixels per line.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port cfg_pattern, input, 2, Bayer phase: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
REQ-006 SHALL have ports s_r, s_g, s_b, input, PIX_W each, RGB pixel in.
REQ-007 SHALL have ports s_valid/s_sof/s_eol, input, 1 each, and s_ready, output, 1: input beat, first pixel of frame, last pixel of line.
REQ-008 SHALL have port m_data, output, PIX_W, raw mosaic sample.
REQ-009 SHALL have ports m_valid/m_sof/m_eol, output, 1 each, and m_ready, input, 1.
REQ-010 SHALL have port err_clr, input, 1, clears sticky errors.
REQ-011 SHALL have port err_width, output, 1, sticky: line length differs from IMG_WIDTH.
REQ-012 SHALL have port err_sof, output, 1, sticky: sof seen mid-line.
REQ-013 SHALL have port frame_cnt, output, 16, count of accepted sof beats.

Function
REQ-014 Input transfer occurs iff s_valid && s_ready; output transfer occurs iff m_valid && m_ready.
REQ-015 SHALL use a 2-entry output skid buffer; s_ready = buffer not full, registered, no combinational path from m_ready.
REQ-016 Latency: accepted beat SHALL appear on m_* the next cycle when buffer empty; throughput 1 beat/cycle with m_ready held high.
REQ-017 Data SHALL leave in acceptance order; m_valid SHALL stay high and m_* stable until accepted.
REQ-018 col_par SHALL be 0 on a sof beat and on the beat after an eol beat, otherwise toggle per accepted beat.
REQ-019 row_par SHALL be 0 on a sof beat and toggle on the beat after each eol beat.
REQ-020 Effective pattern SHALL be latched from cfg_pattern on each sof beat; changes mid-frame ignored.
REQ-021 Site select: idx = {row_par,col_par} XOR latched pattern; idx 0=R, 1=G, 2=G, 3=B; m_data = selected channel unchanged (no arithmetic, no clipping).
REQ-022 m_sof/m_eol SHALL be passed through aligned with their pixel.
REQ-023 col_cnt (clog2(IMG_WIDTH)+1 bits) SHALL reset to 0 on sof beat and after eol beat, else increment.
REQ-024 eol beat with col_cnt != IMG_WIDTH-1 SHALL set err_width.
REQ-025 Beat with col_cnt == IMG_WIDTH-1 and no eol SHALL set err_width and wrap col_cnt/col_par to 0 and toggle row_par as if eol.
REQ-026 sof beat with col_cnt != 0 SHALL set err_sof; parity/counter still restart.
REQ-027 err_clr SHALL clear both flags; a simultaneous set condition wins.
REQ-028 frame_cnt SHALL increment on each accepted sof beat, wrapping 0xFFFF->0.
REQ-029 sof and eol on same beat SHALL be legal (1-pixel line with IMG_WIDTH=1 only; else err_width).

Reset
REQ-030 While rst_n low: m_valid=0, s_ready=0, m_data=0, m_sof=0, m_eol=0, errors=0, frame_cnt=0, parities/counters=0, pattern=RGGB.
REQ-031 s_ready SHALL rise the first clk edge after rst_n deasserts; in-flight beats at reset are discarded.

Structure
REQ-032 Shared package demosaic_pkg SHALL hold PIX_W default, bayer_pattern_t enum (RGGB, GRBG, GBRG, BGGR) and site-index constants, reused by the demosaic interpolators.
REQ-033 Skid buffer SHALL be a sub-module mosaic_skid_buf (parameterised width, 2 entries).

Verification
REQ-034 RGGB, IMG_WIDTH=4, 2 lines of R=0x100,G=0x200,B=0x300 -> m_data 100,200,100,200 / 200,300,200,300; m_eol on 4th and 8th.
REQ-035 cfg_pattern=3 at sof, switched to 0 mid-frame -> line0 starts B=0x300, G; switch ignored until next sof.
REQ-036 m_ready low 5 cycles during stream -> s_ready low within 2 cycles, no beat lost/duplicated, order preserved.
REQ-037 eol after 3 pixels (IMG_WIDTH=4) -> err_width=1; err_clr pulse -> 0; missing eol on 4th -> err_width=1 and parity wraps.
REQ-038 sof at col 2 -> err_sof=1, frame_cnt+1, next pixel uses row0/col0 site.
REQ-039 rst_n low mid-line with m_valid=1 -> all outputs 0 asynchronously; after release new sof restarts cleanly.
